// File: rtl/pcie_symbols_pkg.sv
// PCIe link symbol constants and framing helpers, shared by the striper and unstriper.
package pcie_symbols_pkg;

    localparam int unsigned SYM_W = 8;

    localparam logic [SYM_W-1:0] COM = 8'hBC;
    localparam logic [SYM_W-1:0] PAD = 8'hF7;
    localparam logic [SYM_W-1:0] SKP = 8'h1C;
    localparam logic [SYM_W-1:0] STP = 8'hFB;
    localparam logic [SYM_W-1:0] SDP = 8'h5C;
    localparam logic [SYM_W-1:0] END = 8'hFD;
    localparam logic [SYM_W-1:0] EDB = 8'hFE;
    localparam logic [SYM_W-1:0] FTS = 8'h3C;
    localparam logic [SYM_W-1:0] IDL = 8'h7C;

    // Striper FSM: S_ALIGN is a single-cycle detour to move a held start symbol to lane 0.
    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_ALIGN = 1'b1
    } stripe_state_e;

    // Symbols that must open a group on lane 0.
    function automatic logic is_start(input logic [SYM_W-1:0] sym, input logic k);
        return k && ((sym == STP) || (sym == SDP) || (sym == COM));
    endfunction

    // Symbols that close the current group, PAD-filling the remaining lanes.
    function automatic logic is_end(input logic [SYM_W-1:0] sym, input logic k);
        return k && ((sym == END) || (sym == EDB));
    endfunction

endpackage

// File: rtl/striping_stage.sv
// Four-slot staging buffer. The group view merges the byte being written this cycle and
// replaces every slot at or above i_pad_from with a K-flagged PAD.
module striping_stage
    import pcie_symbols_pkg::*;
(
    input  logic        clk,
    input  logic        reset_L,
    input  logic        i_wr_en,
    input  logic [1:0]  i_wr_idx,
    input  logic [7:0]  i_wr_byte,
    input  logic        i_wr_k,
    input  logic [2:0]  i_pad_from,   // 4 means no PAD fill
    output logic [31:0] o_grp_data,   // lane i in bits [8*i +: 8]
    output logic [3:0]  o_grp_k
);

    logic [7:0] r_slot [4];
    logic [3:0] r_k;

    // Slot storage; only the addressed slot changes on a write.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < 4; i++) begin
                r_slot[i] <= '0;
            end
            r_k <= '0;
        end else if (i_wr_en) begin
            r_slot[i_wr_idx] <= i_wr_byte;
            r_k[i_wr_idx]    <= i_wr_k;
        end
    end

    // Group as it would look after this cycle's write, with PAD fill applied.
    always_comb begin
        o_grp_data = '0;
        o_grp_k    = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) >= i_pad_from) begin
                o_grp_data[8*i +: 8] = PAD;
                o_grp_k[i]           = 1'b1;
            end else if (i_wr_en && (i_wr_idx == 2'(i))) begin
                o_grp_data[8*i +: 8] = i_wr_byte;
                o_grp_k[i]           = i_wr_k;
            end else begin
                o_grp_data[8*i +: 8] = r_slot[i];
                o_grp_k[i]           = r_k[i];
            end
        end
    end

endmodule

// File: rtl/striping.sv
// Transmit byte striper: serial bytes go round-robin onto four lanes, one aligned group at a
// time. Start symbols are forced onto lane 0, end symbols close the group with PAD.
module striping
    import pcie_symbols_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_LANES = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] fromMux,
    input  logic              fromMux_k,
    input  logic              valid_in,
    output logic              ready_out,
    output logic [DATA_W-1:0] TL0,
    output logic [DATA_W-1:0] TL1,
    output logic [DATA_W-1:0] TL2,
    output logic [DATA_W-1:0] TL3,
    output logic [3:0]        TLk,
    output logic              valid_out
);

    if (DATA_W != 8 || NUM_LANES != 4) begin : g_param_check
        $error("striping supports only DATA_W=8 and NUM_LANES=4");
    end

    stripe_state_e r_state, w_state_d;
    logic [1:0]    r_ptr, w_ptr_d;
    logic [7:0]    r_hold, w_hold_d;
    logic          r_ready, w_ready_d;
    logic [7:0]    r_tl [4];
    logic [3:0]    r_tlk;
    logic          r_valid;

    logic          w_accept;
    logic          w_emit;
    logic          w_wr_en;
    logic [1:0]    w_wr_idx;
    logic [7:0]    w_wr_byte;
    logic          w_wr_k;
    logic [2:0]    w_pad_from;
    logic [31:0]   w_grp_data;
    logic [3:0]    w_grp_k;

    assign w_accept = valid_in && r_ready && (r_state == S_FILL);

    striping_stage u_stage (
        .clk        (clk),
        .reset_L    (reset_L),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (w_wr_idx),
        .i_wr_byte  (w_wr_byte),
        .i_wr_k     (w_wr_k),
        .i_pad_from (w_pad_from),
        .o_grp_data (w_grp_data),
        .o_grp_k    (w_grp_k)
    );

    // Next-state: slot writes, pointer advance, framing and the lane-0 realignment detour.
    always_comb begin
        w_state_d  = r_state;
        w_ptr_d    = r_ptr;
        w_hold_d   = r_hold;
        w_ready_d  = 1'b1;
        w_emit     = 1'b0;
        w_wr_en    = 1'b0;
        w_wr_idx   = r_ptr;
        w_wr_byte  = fromMux;
        w_wr_k     = fromMux_k;
        w_pad_from = 3'd4;
        unique case (r_state)
            S_ALIGN: begin
                // Held start symbol opens the new group on lane 0; input is ignored here.
                w_wr_en   = 1'b1;
                w_wr_idx  = 2'd0;
                w_wr_byte = r_hold;
                w_wr_k    = 1'b1;
                w_ptr_d   = 2'd1;
                w_state_d = S_FILL;
            end
            default: begin
                if (w_accept) begin
                    if (is_end(fromMux, fromMux_k)) begin
                        w_wr_en    = 1'b1;
                        w_pad_from = {1'b0, r_ptr} + 3'd1;
                        w_emit     = 1'b1;
                        w_ptr_d    = 2'd0;
                    end else if (is_start(fromMux, fromMux_k) && (r_ptr != 2'd0)) begin
                        // Flush the partial group and park the start symbol for S_ALIGN.
                        w_pad_from = {1'b0, r_ptr};
                        w_emit     = 1'b1;
                        w_hold_d   = fromMux;
                        w_ptr_d    = 2'd0;
                        w_state_d  = S_ALIGN;
                        w_ready_d  = 1'b0;
                    end else begin
                        w_wr_en = 1'b1;
                        w_emit  = (r_ptr == 2'd3);
                        w_ptr_d = r_ptr + 2'd1;
                    end
                end
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= S_FILL;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_ptr   <= w_ptr_d;
            r_hold  <= w_hold_d;
            r_ready <= w_ready_d;
        end
    end

    // Lane outputs: the completed group for one cycle, IDL otherwise.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < 4; i++) begin
                r_tl[i] <= IDL;
            end
            r_tlk   <= 4'hF;
            r_valid <= 1'b0;
        end else if (w_emit) begin
            for (int i = 0; i < 4; i++) begin
                r_tl[i] <= w_grp_data[8*i +: 8];
            end
            r_tlk   <= w_grp_k;
            r_valid <= 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_tl[i] <= IDL;
            end
            r_tlk   <= 4'hF;
            r_valid <= 1'b0;
        end
    end

    assign TL0       = r_tl[0];
    assign TL1       = r_tl[1];
    assign TL2       = r_tl[2];
    assign TL3       = r_tl[3];
    assign TLk       = r_tlk;
    assign valid_out = r_valid;
    assign ready_out = r_ready;

endmodule

// File: tb/tb_striping.sv
// Scoreboard bench for the lane striper: stimulus pushes expected groups, a negedge monitor
// pops and compares every emitted group and checks for IDL between groups.
module tb_striping;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic [7:0] fromMux = 8'h00;
    logic       fromMux_k = 1'b0;
    logic       valid_in = 1'b0;
    logic       ready_out;
    logic [7:0] TL0, TL1, TL2, TL3;
    logic [3:0] TLk;
    logic       valid_out;

    typedef struct packed {
        logic [31:0] data;   // lane3..lane0, MSB first
        logic [3:0]  k;
    } grp_t;

    grp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    striping dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .fromMux   (fromMux),
        .fromMux_k (fromMux_k),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .TL0       (TL0),
        .TL1       (TL1),
        .TL2       (TL2),
        .TL3       (TL3),
        .TLk       (TLk),
        .valid_out (valid_out)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    // One cycle of input; returns at posedge+1 with the byte presented across that edge.
    task automatic drive(input logic [7:0] b, input logic k, input logic v);
        fromMux   = b;
        fromMux_k = k;
        valid_in  = v;
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic expect_grp(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                              input logic [7:0] l3, input logic [3:0] k);
        grp_t g;
        g.data = {l3, l2, l1, l0};
        g.k    = k;
        exp_q.push_back(g);
    endtask

    // Monitor: every valid group must match the queue head; idle cycles must show IDL.
    initial begin
        grp_t g;
        forever begin
            @(negedge clk);
            if (valid_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_group", {28'h0, TLk, TL3, TL2, TL1, TL0}, 64'h0);
                end else begin
                    g = exp_q.pop_front();
                    chk("grp_lanes", {32'h0, TL3, TL2, TL1, TL0}, {32'h0, g.data});
                    chk("grp_k", {60'h0, TLk}, {60'h0, g.k});
                end
            end else begin
                chk("idle_lanes", {32'h0, TL3, TL2, TL1, TL0}, 64'h7C7C7C7C);
                chk("idle_k", {60'h0, TLk}, 64'hF);
                chk("idle_valid", {63'h0, valid_out}, 64'h0);
            end
        end
    end

    // Watchdog so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset then idle.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("reset_ready", {63'h0, ready_out}, 64'h1);
        end
        reset_L = 1'b1;
        idle(2);
        chk("ready_after_reset", {63'h0, ready_out}, 64'h1);

        // Aligned packet.
        drive(8'hFB, 1'b1, 1'b1);
        drive(8'hFF, 1'b0, 1'b1);
        drive(8'hFF, 1'b0, 1'b1);
        expect_grp(8'hFB, 8'hFF, 8'hFF, 8'hFD, 4'b1001);
        drive(8'hFD, 1'b1, 1'b1);
        idle(2);

        // Early END, then a plain data group starting on lane 0.
        drive(8'hFB, 1'b1, 1'b1);
        drive(8'hAA, 1'b0, 1'b1);
        expect_grp(8'hFB, 8'hAA, 8'hFD, 8'hF7, 4'b1101);
        drive(8'hFD, 1'b1, 1'b1);
        drive(8'h11, 1'b0, 1'b1);
        drive(8'h22, 1'b0, 1'b1);
        drive(8'h33, 1'b0, 1'b1);
        expect_grp(8'h11, 8'h22, 8'h33, 8'h44, 4'b0000);
        drive(8'h44, 1'b0, 1'b1);
        idle(2);

        // Misaligned start: partial flush, one-cycle stall, SDP moved to lane 0.
        drive(8'h01, 1'b0, 1'b1);
        drive(8'h02, 1'b0, 1'b1);
        expect_grp(8'h01, 8'h02, 8'hF7, 8'hF7, 4'b1100);
        drive(8'h5C, 1'b1, 1'b1);
        chk("align_ready_low", {63'h0, ready_out}, 64'h0);
        drive(8'hEE, 1'b0, 1'b1);  // must be ignored
        chk("align_ready_back", {63'h0, ready_out}, 64'h1);
        drive(8'h03, 1'b0, 1'b1);
        drive(8'h04, 1'b0, 1'b1);
        expect_grp(8'h5C, 8'h03, 8'h04, 8'h05, 4'b0001);
        drive(8'h05, 1'b0, 1'b1);
        idle(2);

        // Data FB/FD with K=0 and 5-cycle gaps: no framing action.
        drive(8'hFB, 1'b0, 1'b1);
        idle(5);
        drive(8'hFD, 1'b0, 1'b1);
        idle(5);
        drive(8'h12, 1'b0, 1'b1);
        idle(5);
        expect_grp(8'hFB, 8'hFD, 8'h12, 8'h34, 4'b0000);
        drive(8'h34, 1'b0, 1'b1);
        idle(2);

        // Reset mid-group, off a clock edge.
        drive(8'hA1, 1'b0, 1'b1);
        drive(8'hA2, 1'b0, 1'b1);
        #2;
        reset_L = 1'b0;
        #1;
        chk("rst_lanes", {32'h0, TL3, TL2, TL1, TL0}, 64'h7C7C7C7C);
        chk("rst_k", {60'h0, TLk}, 64'hF);
        chk("rst_valid", {63'h0, valid_out}, 64'h0);
        chk("rst_ready", {63'h0, ready_out}, 64'h1);
        #2;
        reset_L = 1'b1;
        @(posedge clk);
        #1;
        drive(8'hB1, 1'b0, 1'b1);
        drive(8'hB2, 1'b0, 1'b1);
        drive(8'hB3, 1'b1, 1'b1);
        expect_grp(8'hB1, 8'hB2, 8'hB3, 8'hB4, 4'b0100);
        drive(8'hB4, 1'b0, 1'b1);
        idle(3);

        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
